dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 61 ++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data-memory arbiter; m0 has priority, m1 forced in after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          stall_pipe,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, RESP0, RESP1} state_t;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          force_m1;
  always_comb begin
    force_m1   = m1_req && (wait_q == WW'(MAX_WAIT));
    m1_gnt     = !RST && m1_req && (!m0_req || force_m1);
    m0_gnt     = !RST && m0_req && !m1_gnt;
    stall_pipe = !RST && m0_req && !m0_gnt;
    mem_en     = m0_gnt || m1_gnt;
    mem_we     = m0_gnt ? m0_we : (m1_gnt && m1_we);
    mem_addr   = m1_gnt ? m1_addr : m0_addr;
    mem_wdata  = m1_gnt ? m1_wdata : m0_wdata;
    wait_d     = (m1_req && !m1_gnt) ? ((wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1) : '0;
    state_d    = (m0_gnt && !m0_we) ? RESP0 : (m1_gnt && !m1_we) ? RESP1 : IDLE;
    // reset masks a response still in flight
    m0_rvalid  = !RST && (state_q == RESP0);
    m1_rvalid  = !RST && (state_q == RESP1);
    m0_rdata   = m0_rvalid ? mem_rdata : '0;
    m1_rdata   = m1_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
endmodule
